mem_checker_native_multi: RTL and testbench

//  Parametrised successor to the native-port DDR memory checker. Writes a selectable data pattern over [START_ADDR..END_ADDR],

---
 rtl/mem_checker_native_multi.sv | 198 +++++++++++++++++++
 tb/tb_mem_checker_native_multi.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_checker_native_multi.sv
// Native-port memory checker: writes a pattern over an address range, reads it back with bounded outstanding reads, compares every beat.
// Compare result lands 1 cycle after rd_valid; writes stall on wr_busy until accepted, reads stall on rd_busy or the outstanding limit.
module mem_checker_native_multi #(
  parameter int          DATA_WIDTH      = 128,
  parameter logic [31:0] START_ADDR      = 32'h0000_0000,
  parameter logic [31:0] END_ADDR        = 32'h0000_0100,
  parameter logic [31:0] ADDR_STEP       = 32'd1,
  parameter int          NUM_PASSES      = 1,
  parameter int          MAX_OUTSTANDING = 8,
  parameter int          ERR_CNT_WIDTH   = 16,
  parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     test_start,
  input  logic [1:0]               pattern_sel,
  input  logic                     wr_busy,
  output logic                     wr_en,
  output logic [31:0]              wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [DATA_WIDTH/8-1:0]  wr_datamask,
  input  logic                     wr_ack,
  input  logic                     rd_busy,
  output logic                     rd_en,
  output logic [31:0]              rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  input  logic                     rd_valid,
  output logic                     test_busy,
  output logic                     test_done,
  output logic                     test_pass,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [31:0]              first_err_addr,
  output logic                     first_err_valid,
  output logic [15:0]              pass_count
);
  localparam int          LANES     = DATA_WIDTH / 32;
  localparam int          WALK_W    = $clog2(DATA_WIDTH);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam bit          EMPTY     = END_ADDR < START_ADDR;
  localparam logic [8:0]  MAX_OUT   = 9'(MAX_OUTSTANDING);
  localparam logic [31:0] PASSES    = 32'(NUM_PASSES);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic              start_q;
  logic [1:0]        pat_q;
  logic [31:0]       wr_lfsr, chk_addr, chk_lfsr;
  logic [WALK_W-1:0] wr_walk, chk_walk;
  logic [8:0]        out_cnt, out_nxt;
  logic [32:0]       wr_sum, rd_sum;
  logic [DATA_WIDTH-1:0] chk_exp;
  logic start_rise, wr_acc, rd_iss, in_run, rd_ret, stray, mismatch;
  logic wr_last, rd_last, pass_more;

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [WALK_W-1:0] walk_adv(input logic [WALK_W-1:0] w);
    return (w == WALK_W'(DATA_WIDTH - 1)) ? '0 : w + WALK_W'(1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] gen(input logic [1:0] pat, input logic [31:0] addr,
                                                input logic [31:0] lfsr, input logic [WALK_W-1:0] walk,
                                                input logic [15:0] pc);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int j = 0; j < LANES; j++) begin
      case (pat)
        2'd0:    d[j*32 +: 32] = addr ^ 32'(j);
        2'd1:    d[j*32 +: 32] = lfsr ^ {16'(j), pc};
        2'd3:    d[j*32 +: 32] = ~(addr ^ 32'(j));
        default: ;
      endcase
    end
    if (pat == 2'd2) d[walk] = 1'b1;
    return d;
  endfunction

  assign start_rise  = test_start && !start_q;
  assign wr_acc      = wr_en && (wr_ack || !wr_busy);
  assign rd_iss      = rd_en && !rd_busy;
  assign in_run      = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign rd_ret      = rd_valid && in_run;
  assign stray       = rd_ret && (out_cnt == 9'd0);
  assign out_nxt     = out_cnt + 9'(rd_iss) - 9'(rd_ret && !stray);
  assign wr_sum      = {1'b0, wr_addr} + {1'b0, ADDR_STEP};
  assign rd_sum      = {1'b0, rd_addr} + {1'b0, ADDR_STEP};
  // Last beat is the one whose successor would pass END_ADDR (or leave the 32-bit space).
  assign wr_last     = wr_sum > {1'b0, END_ADDR};
  assign rd_last     = rd_sum > {1'b0, END_ADDR};
  assign pass_more   = (PASSES == 32'd0) || (({16'd0, pass_count} + 32'd1) < PASSES);
  assign wr_data     = wr_en ? gen(pat_q, wr_addr, wr_lfsr, wr_walk, pass_count) : '0;
  assign wr_datamask = '0;
  assign chk_exp     = gen(pat_q, chk_addr, chk_lfsr, chk_walk, pass_count);
  assign mismatch    = stray || (rd_data != chk_exp);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      start_q         <= 1'b0;
      pat_q           <= 2'd0;
      wr_en           <= 1'b0;
      wr_addr         <= '0;
      wr_lfsr         <= '0;
      wr_walk         <= '0;
      rd_en           <= 1'b0;
      rd_addr         <= '0;
      chk_addr        <= '0;
      chk_lfsr        <= '0;
      chk_walk        <= '0;
      out_cnt         <= '0;
      test_busy       <= 1'b0;
      test_done       <= 1'b0;
      test_pass       <= 1'b0;
      err_count       <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
      pass_count      <= '0;
    end else begin
      start_q <= test_start;
      out_cnt <= in_run ? out_nxt : '0;
      case (state)
        IDLE, DONE: if (start_rise) begin
          pat_q           <= pattern_sel;
          err_count       <= '0;
          first_err_addr  <= '0;
          first_err_valid <= 1'b0;
          pass_count      <= '0;
          test_pass       <= EMPTY;
          test_done       <= EMPTY;
          if (EMPTY) begin
            state <= DONE;
          end else begin
            state     <= WRITE;
            test_busy <= 1'b1;
            wr_en     <= 1'b1;
            wr_addr   <= START_ADDR;
            wr_lfsr   <= LFSR_SEED;
            wr_walk   <= '0;
          end
        end
        WRITE: if (wr_acc) begin
          if (wr_last) begin
            state    <= READ;
            wr_en    <= 1'b0;
            rd_en    <= 1'b1;
            rd_addr  <= START_ADDR;
            chk_addr <= START_ADDR;
            chk_lfsr <= LFSR_SEED;
            chk_walk <= '0;
          end else begin
            wr_addr <= wr_sum[31:0];
            wr_lfsr <= lfsr_adv(wr_lfsr);
            wr_walk <= walk_adv(wr_walk);
          end
        end
        READ: begin
          rd_en <= !(rd_iss && rd_last) && (out_nxt < MAX_OUT);
          if (rd_iss) begin
            rd_addr <= rd_sum[31:0];
            if (rd_last) state <= DRAIN;
          end
        end
        DRAIN: if (out_cnt == 9'd0) begin
          pass_count <= pass_count + 16'd1;
          if (pass_more) begin
            state   <= WRITE;
            wr_en   <= 1'b1;
            wr_addr <= START_ADDR;
            wr_lfsr <= LFSR_SEED;
            wr_walk <= '0;
          end else begin
            state     <= DONE;
            test_busy <= 1'b0;
            test_done <= 1'b1;
            test_pass <= (err_count == '0);
          end
        end
        default: state <= IDLE;
      endcase
      // Check-side generator follows return order, independent of issue timing.
      if (rd_ret) begin
        chk_addr <= chk_addr + ADDR_STEP;
        chk_lfsr <= lfsr_adv(chk_lfsr);
        chk_walk <= walk_adv(chk_walk);
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + 1'b1;
          if (!first_err_valid) begin
            first_err_addr  <= chk_addr;
            first_err_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_checker_native_multi.sv
// Directed bench for mem_checker_native_multi: four configured instances share one memory/controller model.
// Controller model acks writes after a delay and returns reads in order after a fixed latency.
module tb_mem_checker_native_multi;
  localparam int DW = 128;
  localparam logic [31:0] STARTS [4] = '{32'h0, 32'h0, 32'h0, 32'h10};
  localparam logic [31:0] ENDS   [4] = '{32'd15, 32'd63, 32'd31, 32'h0F};
  localparam int          PASSES [4] = '{1, 1, 3, 1};
  localparam int          MAXO   [4] = '{8, 2, 8, 8};
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    pattern_sel = 2'd0;
  logic          wr_busy = 1'b1, wr_ack = 1'b0, rd_busy = 1'b0, rd_valid = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          start_a [4];

  logic          wr_en_a [4], rd_en_a [4], busy_a [4], done_a [4], pass_a [4], fev_a [4];
  logic [31:0]   wr_addr_a [4], rd_addr_a [4], fea_a [4];
  logic [DW-1:0] wr_data_a [4];
  logic [DW/8-1:0] mask_a [4];
  logic [15:0]   err_a [4], pc_a [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_checker_native_multi #(
      .DATA_WIDTH(DW), .START_ADDR(STARTS[g]), .END_ADDR(ENDS[g]), .ADDR_STEP(32'd1),
      .NUM_PASSES(PASSES[g]), .MAX_OUTSTANDING(MAXO[g]), .ERR_CNT_WIDTH(16), .LFSR_SEED(SEED)
    ) u_dut (
      .clk(clk), .reset(reset), .test_start(start_a[g]), .pattern_sel(pattern_sel),
      .wr_busy(wr_busy), .wr_en(wr_en_a[g]), .wr_addr(wr_addr_a[g]), .wr_data(wr_data_a[g]),
      .wr_datamask(mask_a[g]), .wr_ack(wr_ack), .rd_busy(rd_busy), .rd_en(rd_en_a[g]),
      .rd_addr(rd_addr_a[g]), .rd_data(rd_data), .rd_valid(rd_valid), .test_busy(busy_a[g]),
      .test_done(done_a[g]), .test_pass(pass_a[g]), .err_count(err_a[g]),
      .first_err_addr(fea_a[g]), .first_err_valid(fev_a[g]), .pass_count(pc_a[g])
    );
  end

  int sel = 0;
  logic          s_wr_en, s_rd_en, s_busy, s_done, s_pass, s_fev;
  logic [31:0]   s_wr_addr, s_rd_addr, s_fea;
  logic [DW-1:0] s_wr_data;
  logic [DW/8-1:0] s_mask;
  logic [15:0]   s_err, s_pc;
  logic [DW+DW/8+32*3+16*2+6-1:0] all_out;

  always_comb begin
    s_wr_en = wr_en_a[sel]; s_rd_en = rd_en_a[sel]; s_busy = busy_a[sel]; s_done = done_a[sel];
    s_pass = pass_a[sel]; s_fev = fev_a[sel]; s_wr_addr = wr_addr_a[sel]; s_rd_addr = rd_addr_a[sel];
    s_fea = fea_a[sel]; s_wr_data = wr_data_a[sel]; s_mask = mask_a[sel]; s_err = err_a[sel]; s_pc = pc_a[sel];
    all_out = {s_wr_en, s_rd_en, s_busy, s_done, s_pass, s_fev, s_wr_addr, s_rd_addr, s_fea,
               s_wr_data, s_mask, s_err, s_pc};
  end

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [DW-1:0] bgen(input int pat, input logic [31:0] addr, input logic [31:0] lf,
                                         input int k, input int pc);
    logic [DW-1:0] d;
    d = '0;
    for (int j = 0; j < DW / 32; j++) begin
      if (pat == 0) d[j*32 +: 32] = addr ^ 32'(j);
      if (pat == 1) d[j*32 +: 32] = lf ^ {j[15:0], pc[15:0]};
      if (pat == 3) d[j*32 +: 32] = ~(addr ^ 32'(j));
    end
    if (pat == 2) d[k % DW] = 1'b1;
    return d;
  endfunction

  typedef struct { logic [31:0] addr; int due; } rq_t;
  rq_t           rq [$];
  logic [DW-1:0] mem [logic [31:0]];
  logic [DW-1:0] first_data [2];
  logic [31:0]   wlf, flip_addr = 32'd5, ra;
  logic [15:0]   err_before, err_after;
  int cyc = 0, wr_seen = 0, wr_delay = 1, rand_busy = 0, lat = 3, flip_on = 0, cur_pat = 0;
  int wr_cnt = 0, rd_iss_cnt = 0, rd_ret_cnt = 0, outst = 0, max_out = 0, wr_bad = 0, any_en = 0;
  int wk = 0, wpass = -1, flip_cyc = -100;
  int errors = 0, checks = 0;

  always @(negedge clk) begin
    cyc++;
    if (cyc == flip_cyc + 1) err_after = s_err;
    if (s_wr_en || s_rd_en) any_en = 1;
    wr_ack = 1'b0;
    wr_busy = 1'b1;
    if (s_wr_en) begin
      if (wr_seen >= wr_delay) begin
        wr_busy = 1'b0;
        wr_ack = (rand_busy != 0 && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
        wr_seen = 0;
        wr_delay = (rand_busy != 0) ? int'($urandom_range(1, 4)) : 1;
        if (s_wr_addr == STARTS[sel]) begin
          wk = 0; wlf = SEED; wpass++;
        end
        if (s_wr_data !== bgen(cur_pat, s_wr_addr, wlf, wk, wpass)) wr_bad++;
        if (s_wr_addr == 32'd0 && wpass >= 0 && wpass < 2) first_data[wpass] = s_wr_data;
        mem[s_wr_addr] = s_wr_data;
        wr_cnt++; wk++; wlf = lfsr_adv(wlf);
      end else begin
        wr_seen++;
      end
    end
    rd_valid = 1'b0;
    rd_busy = (rand_busy != 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      ra = rq[0].addr;
      rq.pop_front();
      rd_valid = 1'b1;
      rd_data = mem.exists(ra) ? mem[ra] : '0;
      if (flip_on != 0 && ra == flip_addr) begin
        rd_data[0] = ~rd_data[0];
        flip_cyc = cyc;
        err_before = s_err;
      end
      rd_ret_cnt++; outst--;
    end
    if (s_rd_en && !rd_busy) begin
      rq.push_back('{s_rd_addr, cyc + lat});
      rd_iss_cnt++; outst++;
      if (outst > max_out) max_out = outst;
    end
  end

  task automatic prep(input int s, input int pat, input int flip, input int rb, input int l);
    sel = s; cur_pat = pat; pattern_sel = pat[1:0]; flip_on = flip; rand_busy = rb; lat = l;
    wr_cnt = 0; rd_iss_cnt = 0; rd_ret_cnt = 0; outst = 0; max_out = 0; wr_bad = 0; any_en = 0;
    wr_seen = 0; wr_delay = 1; wpass = -1; flip_cyc = -100; err_before = '1; err_after = '0;
    mem.delete(); rq.delete();
  endtask

  task automatic kick(input int s);
    @(negedge clk); start_a[s] = 1'b1;
    @(negedge clk); start_a[s] = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 8000 && !s_done; i++) @(negedge clk);
    checks++;
    if (s_done !== 1'b1) begin errors++; $display("FAIL %s_timeout test_done=%b want=1", name, s_done); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s; #1;
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL reset_outputs dut=%0d got=%h want=0", s, all_out); end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    prep(0, 0, 0, 0, 3); kick(0); wait_done("basic");
    checks++; if (s_pass !== 1'b1) begin errors++; $display("FAIL basic_pass got=%b want=1", s_pass); end
    checks++; if (s_err !== 16'd0) begin errors++; $display("FAIL basic_err got=%0d want=0", s_err); end
    checks++; if (wr_cnt != 16) begin errors++; $display("FAIL basic_writes got=%0d want=16", wr_cnt); end
    checks++; if (rd_ret_cnt != 16 || rd_iss_cnt != 16) begin
      errors++; $display("FAIL basic_reads issued=%0d returned=%0d want=16", rd_iss_cnt, rd_ret_cnt); end
    checks++; if (wr_bad != 0) begin errors++; $display("FAIL basic_wdata bad_beats=%0d want=0", wr_bad); end
    checks++; if (s_busy !== 1'b0 || s_fev !== 1'b0) begin
      errors++; $display("FAIL basic_flags busy=%b fev=%b want=0/0", s_busy, s_fev); end
  endtask

  task automatic test_patterns();
    for (int p = 2; p < 4; p++) begin
      prep(0, p, 0, 0, 3); kick(0); wait_done("pattern");
      checks++; if (s_pass !== 1'b1 || wr_bad != 0) begin
        errors++; $display("FAIL pattern%0d pass=%b bad_beats=%0d want=1/0", p, s_pass, wr_bad); end
    end
  endtask

  task automatic test_error();
    prep(0, 0, 1, 0, 3); kick(0); wait_done("error");
    checks++; if (s_err !== 16'd1) begin errors++; $display("FAIL err_count got=%0d want=1", s_err); end
    checks++; if (s_fea !== 32'd5 || s_fev !== 1'b1) begin
      errors++; $display("FAIL first_err addr=%0h valid=%b want=5/1", s_fea, s_fev); end
    checks++; if (s_pass !== 1'b0) begin errors++; $display("FAIL err_pass got=%b want=0", s_pass); end
    checks++; if (err_before !== 16'd0 || err_after !== 16'd1) begin
      errors++; $display("FAIL compare_latency before=%0d after=%0d want=0/1", err_before, err_after); end
  endtask

  task automatic test_back_to_back();
    prep(1, 0, 0, 1, 10); kick(1); wait_done("backpressure");
    checks++; if (max_out > 2) begin errors++; $display("FAIL max_outstanding got=%0d want<=2", max_out); end
    checks++; if (rd_ret_cnt != 64) begin errors++; $display("FAIL bp_reads got=%0d want=64", rd_ret_cnt); end
    checks++; if (s_pass !== 1'b1 || wr_bad != 0) begin
      errors++; $display("FAIL bp_pass pass=%b bad_beats=%0d want=1/0", s_pass, wr_bad); end
  endtask

  task automatic test_multipass();
    prep(2, 1, 0, 0, 3); kick(2); wait_done("multipass");
    checks++; if (s_pc !== 16'd3) begin errors++; $display("FAIL pass_count got=%0d want=3", s_pc); end
    checks++; if (s_pass !== 1'b1) begin errors++; $display("FAIL mp_pass got=%b want=1", s_pass); end
    checks++; if (wr_cnt != 96 || rd_ret_cnt != 96) begin
      errors++; $display("FAIL mp_beats writes=%0d reads=%0d want=96/96", wr_cnt, rd_ret_cnt); end
    checks++; if (wr_bad != 0) begin errors++; $display("FAIL mp_wdata bad_beats=%0d want=0", wr_bad); end
    checks++; if (first_data[0] === first_data[1]) begin
      errors++; $display("FAIL mp_pass_differ pass0=%h pass1=%h want different", first_data[0], first_data[1]); end
  endtask

  task automatic test_reset_midrun();
    prep(0, 0, 0, 0, 3); kick(0);
    for (int i = 0; i < 500 && wr_cnt < 7; i++) @(negedge clk);
    checks++; if (s_wr_en !== 1'b1) begin errors++; $display("FAIL midrun_active wr_en=%b want=1", s_wr_en); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (s_wr_en !== 1'b0) begin errors++; $display("FAIL midrun_wr_en got=%b want=0", s_wr_en); end
    checks++; if (all_out !== '0) begin errors++; $display("FAIL midrun_outputs got=%h want=0", all_out); end
    @(negedge clk); reset = 1'b0;
    prep(0, 0, 0, 0, 3); kick(0); wait_done("restart");
    checks++; if (s_pass !== 1'b1 || wr_cnt != 16) begin
      errors++; $display("FAIL restart_pass pass=%b writes=%0d want=1/16", s_pass, wr_cnt); end
  endtask

  task automatic test_empty();
    prep(3, 0, 0, 0, 3); kick(3);
    checks++; if (s_done !== 1'b1 || s_pass !== 1'b1) begin
      errors++; $display("FAIL empty_done done=%b pass=%b want=1/1", s_done, s_pass); end
    repeat (3) @(negedge clk);
    checks++; if (any_en != 0) begin errors++; $display("FAIL empty_no_req saw_req=%0d want=0", any_en); end
  endtask

  initial begin
    for (int s = 0; s < 4; s++) start_a[s] = 1'b0;
    test_reset();
    test_basic();
    test_patterns();
    test_error();
    test_back_to_back();
    test_multipass();
    test_reset_midrun();
    test_empty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
